// File: rtl/seq_pkg.sv
// Shared types for the step sequencer: FSM state encoding and step index width.
package seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} seq_state_t;

   localparam int STEP_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Tick is registered one count early so it is high while the count sits at LAST.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
         tick_d = (cnt_q == PRE_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/step_sequencer.sv
// Step timer initiator: emits select ticks, advances the step index on done, pulses finished.
// Optional per-step watchdog enabled by defining STEP_TIMEOUT_EN.
module step_sequencer
   import seq_pkg::*;
#(
   parameter int TICK_DIV      = 50000000,
   parameter int NUM_STEPS     = 10,
   parameter int LOOP          = 0,
   parameter int TIMEOUT_TICKS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              done,
   output logic              select,
   output logic [STEP_W-1:0] step,
   output logic              busy,
   output logic              finished,
   output logic              timeout
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   seq_state_t        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              finished_q, finished_d;
   logic              pending_q, pending_d;
   logic              start_q;
   logic              start_rise;
   logic              advance;
   logic              wd_expire;
   logic              tick;
   logic              pre_en;
   logic              pre_clr;

   assign start_rise = start & ~start_q;

   // A done latched during PAUSE is applied on the edge that returns to RUN.
   assign advance = ((state_q == RUN) && done) ||
                    ((state_q == PAUSE) && !pause && (done || pending_q));

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      finished_d = 1'b0;
      pending_d  = pending_q;
      pre_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d   = RUN;
               step_d    = '0;
               pending_d = 1'b0;
               pre_clr   = 1'b1;
            end
         end
         RUN: begin
            if (pause) state_d = PAUSE;
         end
         PAUSE: begin
            if (!pause) begin
               state_d   = RUN;
               pending_d = 1'b0;
            end else if (done) begin
               pending_d = 1'b1;
            end
         end
         FINISH: begin
            if (start_rise) begin
               state_d   = RUN;
               step_d    = '0;
               pending_d = 1'b0;
               pre_clr   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (step_q == LAST_STEP) begin
            finished_d = 1'b1;
            if (LOOP != 0) step_d = '0;
            else           state_d = FINISH;
         end else begin
            step_d = step_q + 1'b1;
         end
      end

      if (wd_expire) begin
         state_d    = IDLE;
         finished_d = 1'b0;
      end
   end

   // Prescaler only runs on cycles that stay in RUN, so no select leaks into PAUSE/FINISH/IDLE.
   assign pre_en = (state_q == RUN) && (state_d == RUN);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (pre_en),
      .clr  (pre_clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         step_q     <= '0;
         finished_q <= 1'b0;
         pending_q  <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         finished_q <= finished_d;
         pending_q  <= pending_d;
         start_q    <= start;
      end
   end

`ifdef STEP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_TICKS - 1);

   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   assign wd_expire = (state_q == RUN) && tick && !advance && (wd_q == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (start_rise) timeout_q <= 1'b0;
         if (wd_expire)  timeout_q <= 1'b1;
         if (pre_clr || advance || wd_expire) wd_q <= '0;
         else if ((state_q == RUN) && tick)   wd_q <= wd_q + 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   logic [31:0] unused_timeout_ticks;
   assign unused_timeout_ticks = 32'(TIMEOUT_TICKS);
   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

   assign select   = tick;
   assign step     = step_q;
   assign busy     = (state_q == RUN) || (state_q == PAUSE);
   assign finished = finished_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scenario bench for step_sequencer: stop-mode, loop-mode and (optionally) watchdog instances.
module tb_step_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0, pause_a = 1'b0, done_a = 1'b0;
   logic       sel_a, busy_a, fin_a, to_a;
   logic [3:0] step_a;
   logic       start_b = 1'b0, pause_b = 1'b0, done_b = 1'b0;
   logic       sel_b, busy_b, fin_b, to_b;
   logic [3:0] step_b;

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   logic [3:0] exp_step[$];
   int         sel_exp[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   step_sequencer #(.TICK_DIV(4), .NUM_STEPS(3), .LOOP(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .done(done_a),
      .select(sel_a), .step(step_a), .busy(busy_a), .finished(fin_a), .timeout(to_a)
   );

   step_sequencer #(.TICK_DIV(4), .NUM_STEPS(2), .LOOP(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .done(done_b),
      .select(sel_b), .step(step_b), .busy(busy_b), .finished(fin_b), .timeout(to_b)
   );

`ifdef STEP_TIMEOUT_EN
   logic       start_c = 1'b0;
   logic       sel_c, busy_c, fin_c, to_c;
   logic [3:0] step_c;

   step_sequencer #(.TICK_DIV(4), .NUM_STEPS(3), .LOOP(0), .TIMEOUT_TICKS(3)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .pause(1'b0), .done(1'b0),
      .select(sel_c), .step(step_c), .busy(busy_c), .finished(fin_c), .timeout(to_c)
   );
`endif

   task automatic test_reset();
      int sel_cnt = 0;
      int busy_cnt = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (sel_a !== 1'b0) $display("FAIL reset_select got %b want 0", sel_a); else passed++;
      checks++; if (step_a !== 4'd0) $display("FAIL reset_step got %0d want 0", step_a); else passed++;
      checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else passed++;
      checks++; if (fin_a !== 1'b0) $display("FAIL reset_finished got %b want 0", fin_a); else passed++;
      checks++; if (to_a !== 1'b0) $display("FAIL reset_timeout got %b want 0", to_a); else passed++;
      checks++; if (step_b !== 4'd0 || busy_b !== 1'b0) $display("FAIL reset_b got step=%0d busy=%b want 0/0", step_b, busy_b); else passed++;
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (sel_a) sel_cnt++;
         if (busy_a) busy_cnt++;
      end
      checks++; if (sel_cnt != 0) $display("FAIL idle_select got %0d pulses want 0", sel_cnt); else passed++;
      checks++; if (busy_cnt != 0) $display("FAIL idle_busy got %0d cycles want 0", busy_cnt); else passed++;
      $display("reset: rst held 2 cycles, 20 idle cycles observed");
   endtask

   task automatic test_basic_run();
      int s;
      int e;
      bit ok;
      int sel_cnt = 0;
      start_a = 1'b1;
      s = cyc;
      for (int i = 1; i <= 6; i++) sel_exp.push_back(s + 4 * i);
      @(negedge clk);
      start_a = 1'b0;
      checks++; if (step_a !== 4'd0 || busy_a !== 1'b1) $display("FAIL start_state got step=%0d busy=%b want 0/1", step_a, busy_a); else passed++;
      for (int i = 1; i <= 6; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            if (sel_a) ok = 1'b1;
         end
         e = sel_exp.pop_front();
         checks++; if (!ok || cyc != e) $display("FAIL select_time got cycle %0d (seen=%b) want %0d", cyc, ok, e); else passed++;
         if (i % 2 == 0) begin
            @(negedge clk);
            done_a = 1'b1;
            exp_step.push_back((i == 6) ? 4'd2 : 4'(i / 2));
            @(negedge clk);
            done_a = 1'b0;
            e = int'(exp_step.pop_front());
            checks++; if (int'(step_a) != e) $display("FAIL run_step got %0d want %0d", step_a, e); else passed++;
            checks++; if (fin_a !== (i == 6)) $display("FAIL run_finished got %b want %b", fin_a, (i == 6)); else passed++;
            $display("run: done #%0d -> step %0d finished %b", i / 2, step_a, fin_a);
         end
      end
      checks++; if (busy_a !== 1'b0) $display("FAIL finish_busy got %b want 0", busy_a); else passed++;
      @(negedge clk);
      checks++; if (fin_a !== 1'b0 || busy_a !== 1'b0 || step_a !== 4'd2)
         $display("FAIL after_finish got fin=%b busy=%b step=%0d want 0/0/2", fin_a, busy_a, step_a); else passed++;
      repeat (10) begin
         @(negedge clk);
         if (sel_a) sel_cnt++;
      end
      checks++; if (sel_cnt != 0) $display("FAIL idle_after_finish_select got %0d want 0", sel_cnt); else passed++;
   endtask

   task automatic test_pause();
      int sel_cnt = 0;
      int e;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      pause_a = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (sel_a) sel_cnt++;
         if (k == 2) begin
            done_a = 1'b1;
            exp_step.push_back(4'd1);
         end
         if (k == 3) done_a = 1'b0;
      end
      checks++; if (sel_cnt != 0) $display("FAIL pause_select got %0d pulses want 0", sel_cnt); else passed++;
      checks++; if (busy_a !== 1'b1) $display("FAIL pause_busy got %b want 1", busy_a); else passed++;
      checks++; if (step_a !== 4'd0) $display("FAIL pause_step_hold got %0d want 0", step_a); else passed++;
      pause_a = 1'b0;
      @(negedge clk);
      e = int'(exp_step.pop_front());
      checks++; if (int'(step_a) != e) $display("FAIL pending_done_step got %0d want %0d", step_a, e); else passed++;
      checks++; if (sel_a !== 1'b0) $display("FAIL resume_early_select got %b want 0", sel_a); else passed++;
      @(negedge clk);
      checks++; if (sel_a !== 1'b1) $display("FAIL resume_select got %b want 1", sel_a); else passed++;
      $display("pause: 10-cycle pause, pending done applied, step %0d", step_a);
   endtask

   task automatic test_reset_midrun_and_start_filter();
      int fin_cnt = 0;
      int busy_cnt = 0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (sel_a !== 1'b0 || step_a !== 4'd0 || busy_a !== 1'b0 || fin_a !== 1'b0)
         $display("FAIL midrun_reset got sel=%b step=%0d busy=%b fin=%b want all 0", sel_a, step_a, busy_a, fin_a); else passed++;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (fin_a) fin_cnt++;
         if (busy_a) busy_cnt++;
      end
      checks++; if (fin_cnt != 0 || busy_cnt != 0) $display("FAIL post_reset_quiet got fin=%0d busy=%0d want 0/0", fin_cnt, busy_cnt); else passed++;
      start_a = 1'b1;
      @(negedge clk);
      checks++; if (busy_a !== 1'b1 || step_a !== 4'd0) $display("FAIL held_start_run got busy=%b step=%0d want 1/0", busy_a, step_a); else passed++;
      fin_cnt = 0;
      repeat (3) begin
         done_a = 1'b1;
         @(negedge clk);
         done_a = 1'b0;
         if (fin_a) fin_cnt++;
         @(negedge clk);
         if (fin_a) fin_cnt++;
      end
      checks++; if (fin_cnt != 1) $display("FAIL held_start_finished got %0d pulses want 1", fin_cnt); else passed++;
      busy_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy_a) busy_cnt++;
      end
      checks++; if (busy_cnt != 0 || step_a !== 4'd2) $display("FAIL held_start_single got busy=%0d step=%0d want 0/2", busy_cnt, step_a); else passed++;
      start_a = 1'b0;
      $display("midrun reset and held start: one restart only");
   endtask

   task automatic test_loop();
      int sel_cnt = 0;
      int e;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      checks++; if (step_b !== 4'd0 || busy_b !== 1'b1) $display("FAIL loop_start got step=%0d busy=%b want 0/1", step_b, busy_b); else passed++;
      for (int i = 1; i <= 2; i++) begin
         done_b = 1'b1;
         exp_step.push_back((i == 2) ? 4'd0 : 4'd1);
         @(negedge clk);
         done_b = 1'b0;
         e = int'(exp_step.pop_front());
         checks++; if (int'(step_b) != e) $display("FAIL loop_step got %0d want %0d", step_b, e); else passed++;
         checks++; if (fin_b !== (i == 2)) $display("FAIL loop_finished got %b want %b", fin_b, (i == 2)); else passed++;
         $display("loop: done #%0d -> step %0d finished %b busy %b", i, step_b, fin_b, busy_b);
         @(negedge clk);
      end
      checks++; if (busy_b !== 1'b1 || fin_b !== 1'b0) $display("FAIL loop_keeps_running got busy=%b fin=%b want 1/0", busy_b, fin_b); else passed++;
      done_b  = 1'b1;
      pause_b = 1'b1;
      exp_step.push_back(4'd1);
      @(negedge clk);
      done_b = 1'b0;
      e = int'(exp_step.pop_front());
      checks++; if (int'(step_b) != e || busy_b !== 1'b1) $display("FAIL done_with_pause got step=%0d busy=%b want %0d/1", step_b, busy_b, e); else passed++;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) start_b = 1'b1;
         if (k == 4) start_b = 1'b0;
         @(negedge clk);
         if (sel_b) sel_cnt++;
      end
      checks++; if (sel_cnt != 0 || step_b !== 4'd1) $display("FAIL paused_after_done got sel=%0d step=%0d want 0/1", sel_cnt, step_b); else passed++;
      pause_b = 1'b0;
      @(negedge clk);
   endtask

`ifdef STEP_TIMEOUT_EN
   task automatic test_timeout();
      int s;
      int t3 = -1;
      int n = 0;
      int fin_cnt = 0;
      start_c = 1'b1;
      s = cyc;
      sel_exp.push_back(s + 12);
      @(negedge clk);
      start_c = 1'b0;
      for (int k = 0; k < 20 && t3 < 0; k++) begin
         @(negedge clk);
         if (fin_c) fin_cnt++;
         if (sel_c) begin
            n++;
            if (n == 3) t3 = cyc;
         end
      end
      checks++; if (t3 != sel_exp.pop_front()) $display("FAIL third_select_time got %0d want %0d", t3, s + 12); else passed++;
      checks++; if (to_c !== 1'b0) $display("FAIL timeout_early got %b want 0", to_c); else passed++;
      @(negedge clk);
      checks++; if (to_c !== 1'b1 || busy_c !== 1'b0 || fin_c !== 1'b0)
         $display("FAIL timeout_fire got to=%b busy=%b fin=%b want 1/0/0", to_c, busy_c, fin_c); else passed++;
      repeat (5) begin
         @(negedge clk);
         if (fin_c) fin_cnt++;
      end
      checks++; if (to_c !== 1'b1 || fin_cnt != 0) $display("FAIL timeout_sticky got to=%b fin=%0d want 1/0", to_c, fin_cnt); else passed++;
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      checks++; if (to_c !== 1'b0 || busy_c !== 1'b1) $display("FAIL timeout_clear got to=%b busy=%b want 0/1", to_c, busy_c); else passed++;
      $display("timeout: fired after 3 selects, cleared by start");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout got no completion want finish");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin
      test_reset();
      test_basic_run();
      test_pause();
      test_reset_midrun_and_start_filter();
      test_loop();
`ifdef STEP_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
